// File: rtl/bus_input_port_if.sv
// rtl/bus_input_port_if.sv - stream and bus signals of the SAP bus input port
// Define BUS_IN_PARITY_EN to add the ext_parity sideband.
interface bus_input_port_if;
  logic [15:0] ext_data;
  logic        ext_valid;
  logic        ext_ready;
  logic        in_read;
  logic [15:0] bus_out;
  logic        bus_drive;
`ifdef BUS_IN_PARITY_EN
  logic        ext_parity;

  modport master (
    output ext_data, ext_valid, ext_parity, in_read,
    input  ext_ready, bus_out, bus_drive
  );
  modport slave (
    input  ext_data, ext_valid, ext_parity, in_read,
    output ext_ready, bus_out, bus_drive
  );
`else
  modport master (
    output ext_data, ext_valid, in_read,
    input  ext_ready, bus_out, bus_drive
  );
  modport slave (
    input  ext_data, ext_valid, in_read,
    output ext_ready, bus_out, bus_drive
  );
`endif
endinterface

// File: rtl/bus_input_port.sv
// rtl/bus_input_port.sv - FIFO-buffered external input port that drives the SAP bus
// Define BUS_IN_PARITY_EN to drop words failing even parity and flag parity_err_o.
module bus_input_port #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  bus_input_port_if.slave bus_if,
  output logic            empty_o,
  output logic            full_o,
  output logic [AW:0]     count_o,
`ifdef BUS_IN_PARITY_EN
  output logic            parity_err_o,
`endif
  output logic            underflow_o
);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          underflow_q, underflow_d;

  logic accept;
  logic word_ok;
  logic wr_en;
  logic pop_en;

  assign full_o            = (count_q == (AW+1)'(DEPTH));
  assign empty_o           = (count_q == '0);
  assign count_o           = count_q;
  assign underflow_o       = underflow_q;
  assign bus_if.ext_ready  = !full_o;
  assign bus_if.bus_drive  = bus_if.in_read & !empty_o;
  // Forced to zero when not driving so the bus mux never sees X.
  assign bus_if.bus_out    = bus_if.bus_drive ? mem_q[rptr_q] : 16'h0000;

  assign accept = bus_if.ext_valid & bus_if.ext_ready;
  assign pop_en = bus_if.bus_drive;

`ifdef BUS_IN_PARITY_EN
  logic parity_err_q, parity_err_d;

  assign word_ok      = ~(^{bus_if.ext_data, bus_if.ext_parity});
  assign parity_err_o = parity_err_q;

  always_comb begin
    parity_err_d = parity_err_q;
    if (accept && !word_ok) parity_err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) parity_err_q <= 1'b0;
    else       parity_err_q <= parity_err_d;
  end
`else
  assign word_ok = 1'b1;
`endif

  // Bad-parity words still complete the handshake; they are just not stored.
  assign wr_en = accept & word_ok;

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (wr_en) begin
      mem_d[wptr_q] = bus_if.ext_data;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop_en) rptr_d = rptr_q + AW'(1);
    unique case ({wr_en, pop_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (bus_if.in_read && empty_o) underflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: doc/bus_input_port.md
Name: bus_input_port

Overview:
- Input port for the 16-bit SAP datapath; the bus-driving counterpart of the bus-loaded registers.
- Accepts words from an external source through a valid/ready handshake and buffers them in a small FIFO.
- Drives the head word onto the shared 16-bit bus when the controller asserts in_read, then pops it.
- Sits between the external I/O pins and the bus mux, in the same position as the A/B/ALU bus sources.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
- ext_data  input  16  word from the external source.
- ext_valid  input  1  ext_data is valid this cycle.
- ext_ready  output  1  port can accept a word this cycle.
- in_read  input  1  controller control word: drive bus from this port and pop.
- bus_out  output  16  head word toward the bus mux.
- bus_drive  output  1  bus mux select/enable for this source.
- empty  output  1  FIFO holds 0 words.
- full  output  1  FIFO holds DEPTH words.
- count  output  AW+1  number of words held, 0..DEPTH.
- underflow  output  1  sticky: in_read seen while empty.

Behaviour:
- Reset (rst=1 at an edge): pointers=0, count=0, underflow=0, all FIFO storage=0. Reset overrides every other event in that cycle. A reset mid-handshake discards all buffered data.
- Reset-state outputs: empty=1, full=0, ext_ready=1, bus_drive=0, bus_out=16'h0000.
- Combinational outputs:
  - ext_ready = !full.
  - empty = (count==0); full = (count==DEPTH).
  - bus_drive = in_read & !empty.
  - bus_out = head entry when bus_drive=1, otherwise 16'h0000, so it is never X on the bus mux.
- Push: when ext_valid & ext_ready at an edge, ext_data is written at the write pointer; the write pointer increments modulo DEPTH.
- Pop: when in_read & !empty at an edge, the read pointer increments modulo DEPTH.
  - The bus consumer (e.g. A or B register write) captures bus_out at that same edge.
  - Read latency is 0 cycles: the head word is on the bus in the cycle in_read is high.
- Simultaneous push and pop with 0<count<DEPTH: both occur and count is unchanged.
- Empty with push and in_read in the same cycle: push only, no pop, bus_drive=0. There is no fall-through, so a word is readable at the earliest one cycle after acceptance.
- Full: ext_ready=0, so no push. A pop in that cycle frees a slot and ext_ready rises in the next cycle; there is no same-cycle refill.
- Pointers wrap naturally with AW bits. count is the only source of the full/empty decision.
- in_read while empty: no pointer change, bus_drive=0, underflow set to 1 at that edge. underflow stays set until rst.
- ext_valid may drop without a transfer; nothing is captured unless ext_ready was also 1.

Optional Feature:
- Macro: BUS_IN_PARITY_EN.
- When defined:
  - Adds input ext_parity (1 bit) and sticky output parity_err (1 bit, reset 0).
  - The handshake still completes for every transfer.
  - Accepted transfers whose ^{ext_data,ext_parity} != 0 (even parity violated) are dropped: not written, count unchanged, parity_err set until rst.
  - Good words behave exactly as without the macro.
- When not defined: no ext_parity or parity_err ports, and every accepted word is written.

Test Plan:
- Reset check: rst=1 for 2 cycles -> empty=1, full=0, ext_ready=1, count=0, bus_drive=0, bus_out=0000, underflow=0.
- Fill and drain: push 1111, 2222, 3333, 4444 on consecutive cycles -> full=1, ext_ready=0, count=4. Then in_read for 4 cycles -> bus_out 1111, 2222, 3333, 4444 in order, then empty=1.
- Wrap and concurrency: hold count=2, then push and pop together for 6 cycles with data A001..A006 -> count stays 2, order preserved across pointer wrap.
- Empty boundary: empty, push BEEF and assert in_read in the same cycle -> bus_drive=0, count=1, underflow=1. The next in_read cycle gives bus_out=BEEF.
- Full boundary: full with ext_valid held and data 5555, pop once -> no push in the pop cycle; 5555 accepted in the following cycle; count returns to 4.
- Reset mid-operation: count=3, rst=1 with ext_valid=1 and in_read=1 -> count=0, empty=1, no push; after rst drops, a pushed word reads back correctly.
- Parity (BUS_IN_PARITY_EN defined): push 0001 with ext_parity=0 -> dropped, parity_err=1, count=0. Then push 0001 with ext_parity=1 -> stored, count=1.
